noc_outport_credit_sched: RTL
=============================

# noc_outport_credit_sched

Per-output-port packet scheduler for the xpipes switch. It arbitrates among N_IN input ports requesting one output and holds the output for the whole packet, from head to tail. It replaces the downstream `busy` level with a credit counter that tracks free slots in the next hop's input buffer. It sits between the input buffers and the output mux/shift stage, and drives that stage's one-hot select and shift control.

## Interface
- N_IN, 4, number of competing input ports
- CREDITS, 4, downstream buffer depth; this is also the credit counter reset value
- CRED_W, 3, credit counter width; must satisfy 2^CRED_W > CREDITS
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high, on clk
- in_valid  in  N_IN  input i presents a flit
- in_ftype  in  2*N_IN  flit type of input i, at bits [2i+1:2i]
- in_match  in  N_IN  routing field of input i's flit selects this output (valid for head and single only)
- credit_ret  in  1  one-cycle pulse: downstream freed one slot
- select  out  N_IN  one-hot mux select; zero when nothing transfers
- in_ack  out  N_IN  flit of input i consumed this cycle
- out_valid  out  1  flit is driven on the output this cycle
- shift_ctl  out  1  a new head or single flit was granted this cycle (trim the path field)
- credits  out  CRED_W  current credit count
- locked  out  1  a packet currently owns the output
- cred_err  out  1  sticky flag: credit returned while the counter was already full

## Operation
- Flit types come from the shared encodings ENC_HEAD, ENC_PAYL, ENC_TAIL, ENC_SING.
- Two states:
  - IDLE: no owner.
  - LOCKED: owner register holds one-hot input index.
- A transfer is allowed only when credits != 0. This condition is called `can_send`.
- IDLE:
  - Candidates are inputs i with in_valid[i] & in_match[i] & (ftype is HEAD or SING).
  - If can_send and any candidate exists, grant exactly one candidate: select = in_ack = grant, out_valid=1, shift_ctl=1.
  - Granted HEAD: go to LOCKED, owner=grant.
  - Granted SING: stay in IDLE.
  - A non-matching input, or a PAYL/TAIL arriving in IDLE, is never granted or acked. This condition is legal and must not corrupt state.
- LOCKED:
  - If in_valid[owner] & can_send: select = in_ack = owner, out_valid=1, shift_ctl=0.
  - An accepted TAIL returns the block to IDLE at the next edge.
  - An accepted HEAD or PAYL keeps the block in LOCKED.
  - All other inputs are held off; their in_ack=0.
- Credit counter:
  - next = credits − out_valid + credit_ret.
  - A simultaneous send and return leaves the count unchanged.
  - credit_ret while credits==CREDITS and no send: the count holds at CREDITS and cred_err is set. Only rst clears cred_err.
  - credits==0: all grants and acks are suppressed. The lock is retained and nothing else changes.
- A TAIL accepted in the same cycle as a head from another input: that head is not granted. It becomes eligible on the next cycle.

## Timing
- select, in_ack, out_valid and shift_ctl are combinational from the inputs and registered state, with zero-cycle latency. Registered state is: state, owner, priority pointer, credits, cred_err.
- Handshake: a flit is consumed exactly on the cycle its in_ack=1. The input holds the flit otherwise.
- A new packet can be granted on the cycle after its predecessor's tail is accepted. Sustained throughput is 1 flit/cycle while credits allow.
- Reset values: state=IDLE, owner=0, pointer=input 0, credits=CREDITS, cred_err=0, locked=0.
- With no in_valid during reset, select, in_ack, out_valid and shift_ctl are all 0.
- rst mid-packet drops the lock and restores full credits. Upstream and downstream reset in the same cycle.

## Configuration
- NOC_SCHED_RROBIN_EN defined: round-robin among candidates.
  - The pointer records the highest-priority input.
  - After any grant made in IDLE, the pointer moves to (granted index + 1) mod N_IN.
  - The pointer is unchanged in LOCKED and on cycles with no grant.
- Undefined: fixed priority, where the lowest index wins. The pointer register is omitted.

## Structure
- The shared header noc_parameters.v holds the FTYPE width, ENC_* encodings and RESET_* definitions. The scheduler defines no new global constants.
- One sub-module, noc_rr_picker: an N_IN-wide one-hot priority picker taking a rotating priority vector, using Dally-style double carry chain. With NOC_SCHED_RROBIN_EN undefined it is instantiated with the priority vector tied to 1.

## Test plan
- Single flits (SING) on inputs 1 and 3 together, credits=4, round-robin on: input 1 is granted in cycle 0 and input 3 in cycle 1. shift_ctl=1 on both cycles and credits reaches 2.
- HEAD, PAYL, TAIL on input 0 while input 2 holds a matching HEAD: input 0 gets 3 consecutive acks and input 2 gets in_ack=0 throughout. Input 2 is granted the cycle after the TAIL.
- Packet of 6 flits with CREDITS=4 and no credit_ret: 4 flits pass and then out_valid=0 with locked=1. One credit_ret pulse lets exactly one more flit pass.
- Send and credit_ret in the same cycle at credits=2: credits stays 2. A credit_ret with credits=4 and idle sets cred_err=1 and credits stays 4.
- rst asserted mid-packet (locked=1, credits=1): next cycle locked=0, credits=4, and a HEAD on another input is granted immediately.
- Fixed-priority build, SING on inputs 0 and 2 every cycle: input 0 is granted every cycle and input 2 is never granted.

Source files
------------

// File: rtl/noc_outport_credit_sched_pkg.sv
// rtl/noc_outport_credit_sched_pkg.sv - shared flit encodings and scheduler state type
package noc_outport_credit_sched_pkg;

  localparam int FTYPE_W = 2;

  localparam logic [FTYPE_W-1:0] ENC_PAYL = 2'b00;
  localparam logic [FTYPE_W-1:0] ENC_HEAD = 2'b01;
  localparam logic [FTYPE_W-1:0] ENC_TAIL = 2'b10;
  localparam logic [FTYPE_W-1:0] ENC_SING = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_t;

  function automatic logic opens_packet(input logic [FTYPE_W-1:0] ft);
    return (ft == ENC_HEAD) || (ft == ENC_SING);
  endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// rtl/noc_rr_picker.sv - one-hot priority picker, rotating priority via doubled carry chain
module noc_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] prio,
  output logic [N-1:0] grant
);

  // The chain is unrolled twice so a carry started at prio can wrap past bit N-1.
  always_comb begin
    logic [2*N-1:0] req2;
    logic [2*N-1:0] prio2;
    logic [2*N:0]   carry;
    logic [2*N-1:0] g;
    req2  = {req, req};
    prio2 = {{N{1'b0}}, prio};
    carry = '0;
    g     = '0;
    for (int i = 0; i < 2*N; i++) begin
      g[i]       = req2[i] & (carry[i] | prio2[i]);
      carry[i+1] = (carry[i] | prio2[i]) & ~req2[i];
    end
    grant = g[N-1:0] | g[2*N-1:N];
  end

endmodule

// File: rtl/noc_outport_credit_sched.sv
// rtl/noc_outport_credit_sched.sv - credit-based per-output packet scheduler (option: NOC_SCHED_RROBIN_EN)
module noc_outport_credit_sched
  import noc_outport_credit_sched_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [FTYPE_W*N_IN-1:0] in_ftype,
  input  logic [N_IN-1:0]         in_match,
  input  logic                    credit_ret,
  output logic [N_IN-1:0]         select,
  output logic [N_IN-1:0]         in_ack,
  output logic                    out_valid,
  output logic                    shift_ctl,
  output logic [CRED_W-1:0]       credits,
  output logic                    locked,
  output logic                    cred_err
);

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

  sched_state_t        state, state_nxt;
  logic [N_IN-1:0]     owner, owner_nxt;
  logic [N_IN-1:0]     cand, grant, prio;
  logic [FTYPE_W-1:0]  grant_ftype, owner_ftype;
  logic                can_send;

  always_comb begin
    cand        = '0;
    grant_ftype = '0;
    owner_ftype = '0;
    for (int i = 0; i < N_IN; i++) begin
      cand[i] = in_valid[i] & in_match[i] & opens_packet(in_ftype[FTYPE_W*i +: FTYPE_W]);
      if (grant[i]) grant_ftype = grant_ftype | in_ftype[FTYPE_W*i +: FTYPE_W];
      if (owner[i]) owner_ftype = owner_ftype | in_ftype[FTYPE_W*i +: FTYPE_W];
    end
  end

  noc_rr_picker #(.N(N_IN)) u_picker (
    .req   (cand),
    .prio  (prio),
    .grant (grant)
  );

`ifdef NOC_SCHED_RROBIN_EN
  logic [N_IN-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= N_IN'(1);
    end else if (state == ST_IDLE && out_valid) begin
      ptr <= {grant[N_IN-2:0], grant[N_IN-1]};
    end
  end

  assign prio = ptr;
`else
  assign prio = N_IN'(1);
`endif

  assign can_send = (credits != '0);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    select    = '0;
    out_valid = 1'b0;
    shift_ctl = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_send && (cand != '0)) begin
          select    = grant;
          out_valid = 1'b1;
          shift_ctl = 1'b1;
          if (grant_ftype == ENC_HEAD) begin
            state_nxt = ST_LOCKED;
            owner_nxt = grant;
          end
        end
      end
      ST_LOCKED: begin
        if (((in_valid & owner) != '0) && can_send) begin
          select    = owner;
          out_valid = 1'b1;
          if (owner_ftype == ENC_TAIL) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_ack = select;
  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // A return with the counter already full and nothing sent would overflow; hold and flag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits  <= CRED_FULL;
      cred_err <= 1'b0;
    end else if (credit_ret && !out_valid && credits == CRED_FULL) begin
      cred_err <= 1'b1;
    end else begin
      credits <= credits + {{(CRED_W-1){1'b0}}, credit_ret} - {{(CRED_W-1){1'b0}}, out_valid};
    end
  end

endmodule
